// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

  // Default geometry: 64 x 32-bit words, two read ports.
  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 6;
  localparam int unsigned DefaultNRead = 2;

  // Address of the optional hardwired-zero register.
  localparam int unsigned ZERO_ADDR = 0;

  // Ceiling log2; clog2(1) = 0. Used to size the pending counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = 1;
    while (v < value) begin
      v      = v << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register plus a running population count.
// Decode sets a bit when it issues a producer; writeback clears it. A set and a
// clear to the same register in the same cycle leave it pending, since the set
// belongs to a newer producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sEna,
  input  logic [ADDR_W-1:0]       sAddr,
  input  logic                    wEna,
  input  logic [ADDR_W-1:0]       wAddr,
  output logic [(1<<ADDR_W)-1:0]  pend,
  output logic [ADDR_W:0]         pendCnt
);

  localparam int unsigned Depth = 1 << ADDR_W;
  // Counter must hold 0..Depth inclusive.
  localparam int unsigned CntW  = clog2(Depth + 1);
  localparam int unsigned OutW  = ADDR_W + 1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [Depth-1:0] pend_d, pend_q;
  logic [CntW-1:0]  cnt_d, cnt_q;

  logic set_valid;
  logic inc;
  logic dec;

  // The zero register can never be marked pending.
  assign set_valid = sEna && !(ZERO_REG && (sAddr == ADDR_W'(ZERO_ADDR)));

  // Effective transitions: 0->1 on a set; 1->0 on a write not overridden by a set.
  assign inc = set_valid && !pend_q[sAddr];
  assign dec = wEna && pend_q[wAddr] && !(set_valid && (sAddr == wAddr));

  // Next-state pending vector: set has priority over clear.
  always_comb begin
    pend_d = pend_q;
    if (wEna) begin
      pend_d[wAddr] = 1'b0;
    end
    if (set_valid) begin
      pend_d[sAddr] = 1'b1;
    end
    if (ZERO_REG) begin
      pend_d[ZERO_ADDR] = 1'b0;
    end
  end

  // Next-state count: both effects on different registers cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CntOne;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // Pending bits and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend    = pend_q;
  assign pendCnt = OutW'(cnt_q);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with one synchronous write port, optional
// hardwired-zero register, optional write-to-read bypass and a pending-write
// scoreboard for RAW hazard detection in the issue stage.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned N_READ   = DefaultNRead,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_READ*ADDR_W-1:0] rAddr,
  output logic [N_READ*DATA_W-1:0] rDout,
  output logic [N_READ-1:0]        rBusy,
  input  logic                     wEna,
  input  logic [ADDR_W-1:0]        wAddr,
  input  logic [DATA_W-1:0]        wDin,
  input  logic                     sEna,
  input  logic [ADDR_W-1:0]        sAddr,
  output logic [ADDR_W:0]          pendCnt,
  output logic                     anyBusy
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_d [Depth];
  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  pend;
  logic              write_en;

  // Writes to the zero register are silently dropped.
  assign write_en = wEna && !(ZERO_REG && (wAddr == ADDR_W'(ZERO_ADDR)));

  // Next-state storage: only the addressed word changes.
  always_comb begin
    mem_d = mem_q;
    if (write_en) begin
      mem_d[wAddr] = wDin;
    end
  end

  // Storage array; reset clears every word and discards an in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .sEna    (sEna),
    .sAddr   (sAddr),
    .wEna    (wEna),
    .wAddr   (wAddr),
    .pend    (pend),
    .pendCnt (pendCnt)
  );

  assign anyBusy = (pendCnt != '0);

  // Independent combinational read ports.
  for (genvar k = 0; k < N_READ; k++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              byp_hit;
    logic              set_hit;

    assign addr    = rAddr[k*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_REG && (addr == ADDR_W'(ZERO_ADDR));
    assign byp_hit = BYPASS && wEna && (wAddr == addr);
    // A same-cycle set means a newer producer, so the bypassed value does not
    // retire the hazard.
    assign set_hit = sEna && (sAddr == addr);

    // Read data select: zero register, then bypass, then storage.
    always_comb begin
      rDout[k*DATA_W +: DATA_W] = mem_q[addr];
      if (is_zero) begin
        rDout[k*DATA_W +: DATA_W] = '0;
      end else if (byp_hit) begin
        rDout[k*DATA_W +: DATA_W] = wDin;
      end
    end

    // Busy indication, masked when the forwarded write resolves the hazard.
    always_comb begin
      rBusy[k] = pend[addr];
      if (is_zero || (byp_hit && !set_hit)) begin
        rBusy[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp. A second instance with the
// bypass disabled shares all inputs to contrast forwarding behaviour.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [11:0] r_addr;
  logic [63:0] r_dout, r_dout_nb;
  logic [1:0]  r_busy, r_busy_nb;
  logic        w_ena;
  logic [5:0]  w_addr;
  logic [31:0] w_din;
  logic        s_ena;
  logic [5:0]  s_addr;
  logic [6:0]  pend_cnt, pend_cnt_nb;
  logic        any_busy, any_busy_nb;

  int checks;
  int errors;

  regfile_mp #(
    .DATA_W (32), .ADDR_W (6), .N_READ (2), .ZERO_REG (1'b1), .BYPASS (1'b1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .rAddr (r_addr), .rDout (r_dout), .rBusy (r_busy),
    .wEna (w_ena), .wAddr (w_addr), .wDin (w_din), .sEna (s_ena), .sAddr (s_addr),
    .pendCnt (pend_cnt), .anyBusy (any_busy)
  );

  regfile_mp #(
    .DATA_W (32), .ADDR_W (6), .N_READ (2), .ZERO_REG (1'b1), .BYPASS (1'b0)
  ) dut_nb (
    .clk (clk), .rst_n (rst_n), .rAddr (r_addr), .rDout (r_dout_nb), .rBusy (r_busy_nb),
    .wEna (w_ena), .wAddr (w_addr), .wDin (w_din), .sEna (s_ena), .sAddr (s_addr),
    .pendCnt (pend_cnt_nb), .anyBusy (any_busy_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_ena = 1'b0;
    s_ena = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (r_dout !== 64'h0 || r_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_read got dout=%h busy=%b exp 0", r_dout, r_busy);
    end
    checks++;
    if (pend_cnt !== 7'd0 || any_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt got cnt=%0d any=%b exp 0/0", pend_cnt, any_busy);
    end
    #11 rst_n = 1'b1;
    // Write r5 and mark r6 pending, then reset between edges.
    w_ena = 1'b1; w_addr = 6'd5; w_din = 32'hDEADBEEF;
    s_ena = 1'b1; s_addr = 6'd6;
    tick();
    idle();
    r_addr = {6'd6, 6'd5};
    #1;
    checks++;
    if (r_dout[31:0] !== 32'hDEADBEEF || pend_cnt !== 7'd1 || r_busy !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset got dout=%h cnt=%0d busy=%b exp deadbeef/1/10",
               r_dout[31:0], pend_cnt, r_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (r_dout[31:0] !== 32'h0 || pend_cnt !== 7'd0 || any_busy !== 1'b0 ||
        r_busy !== 2'b00) begin
      errors++;
      $display("FAIL async_reset got dout=%h cnt=%0d any=%b busy=%b exp 0",
               r_dout[31:0], pend_cnt, any_busy, r_busy);
    end
    // A write presented while reset is held must be discarded.
    w_ena = 1'b1; w_addr = 6'd5; w_din = 32'h00000077;
    tick();
    #2 rst_n = 1'b1;
    idle();
    #1;
    checks++;
    if (r_dout[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_discard got %h exp 0", r_dout[31:0]);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    w_ena = 1'b1; w_addr = 6'd7; w_din = 32'h12345678;
    tick();
    idle();
    r_addr = {6'd7, 6'd7};
    #1;
    checks++;
    if (r_dout !== {32'h12345678, 32'h12345678}) begin
      errors++;
      $display("FAIL write_read got %h exp 1234567812345678", r_dout);
    end
    w_ena = 1'b1; w_addr = 6'd0; w_din = 32'hFFFFFFFF;
    r_addr = {6'd0, 6'd0};
    #1;
    checks++;
    if (r_dout !== 64'h0 || r_dout_nb !== 64'h0) begin
      errors++;
      $display("FAIL zero_bypass got %h/%h exp 0", r_dout, r_dout_nb);
    end
    tick();
    idle();
    #1;
    checks++;
    if (r_dout !== 64'h0 || r_dout_nb !== 64'h0) begin
      errors++;
      $display("FAIL zero_write got %h/%h exp 0", r_dout, r_dout_nb);
    end
  endtask

  task automatic test_bypass();
    w_ena = 1'b1; w_addr = 6'd9; w_din = 32'h11112222;
    tick();
    w_ena = 1'b1; w_addr = 6'd9; w_din = 32'hA5A5A5A5;
    r_addr = {6'd7, 6'd9};
    #1;
    checks++;
    if (r_dout !== {32'h12345678, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL bypass_on got %h exp 12345678a5a5a5a5", r_dout);
    end
    checks++;
    if (r_dout_nb !== {32'h12345678, 32'h11112222}) begin
      errors++;
      $display("FAIL bypass_off got %h exp 1234567811112222", r_dout_nb);
    end
    tick();
    idle();
    #1;
    checks++;
    if (r_dout_nb[31:0] !== 32'hA5A5A5A5 || r_dout[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_after got %h/%h exp a5a5a5a5", r_dout[31:0], r_dout_nb[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    s_ena = 1'b1; s_addr = 6'd3;
    tick();
    idle();
    r_addr = {6'd2, 6'd3};
    #1;
    checks++;
    if (r_busy !== 2'b01 || pend_cnt !== 7'd1 || any_busy !== 1'b1) begin
      errors++;
      $display("FAIL sb_set got busy=%b cnt=%0d any=%b exp 01/1/1",
               r_busy, pend_cnt, any_busy);
    end
    w_ena = 1'b1; w_addr = 6'd3; w_din = 32'h33333333;
    #1;
    checks++;
    if (r_busy !== 2'b00 || r_busy_nb !== 2'b01) begin
      errors++;
      $display("FAIL sb_bypass_busy got %b/%b exp 00/01", r_busy, r_busy_nb);
    end
    tick();
    idle();
    #1;
    checks++;
    if (pend_cnt !== 7'd0 || any_busy !== 1'b0 || r_busy !== 2'b00 ||
        pend_cnt_nb !== 7'd0 || any_busy_nb !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear got cnt=%0d any=%b busy=%b exp 0/0/00",
               pend_cnt, any_busy, r_busy);
    end
    // Write to a non-pending register must not disturb the count.
    w_ena = 1'b1; w_addr = 6'd12; w_din = 32'h1;
    tick();
    idle();
    #1;
    checks++;
    if (pend_cnt !== 7'd0) begin
      errors++;
      $display("FAIL sb_nonpending got %0d exp 0", pend_cnt);
    end
  endtask

  task automatic test_set_clear();
    s_ena = 1'b1; s_addr = 6'd4;
    tick();
    s_ena = 1'b1; s_addr = 6'd4;
    w_ena = 1'b1; w_addr = 6'd4; w_din = 32'h55;
    r_addr = {6'd4, 6'd4};
    #1;
    checks++;
    if (r_busy !== 2'b11 || r_dout[31:0] !== 32'h55) begin
      errors++;
      $display("FAIL setclr_comb got busy=%b dout=%h exp 11/55", r_busy, r_dout[31:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (r_busy !== 2'b11 || pend_cnt !== 7'd1 || r_dout[31:0] !== 32'h55) begin
      errors++;
      $display("FAIL setclr_same got busy=%b cnt=%0d dout=%h exp 11/1/55",
               r_busy, pend_cnt, r_dout[31:0]);
    end
    // Set r10 while clearing r4: net change zero.
    s_ena = 1'b1; s_addr = 6'd10;
    w_ena = 1'b1; w_addr = 6'd4; w_din = 32'h66;
    tick();
    idle();
    r_addr = {6'd10, 6'd4};
    #1;
    checks++;
    if (pend_cnt !== 7'd1 || r_busy !== 2'b10) begin
      errors++;
      $display("FAIL setclr_diff got cnt=%0d busy=%b exp 1/10", pend_cnt, r_busy);
    end
    w_ena = 1'b1; w_addr = 6'd10; w_din = 32'h0;
    tick();
    idle();
    #1;
    checks++;
    if (pend_cnt !== 7'd0) begin
      errors++;
      $display("FAIL setclr_drain got %0d exp 0", pend_cnt);
    end
  endtask

  task automatic test_count_stress();
    for (int i = 1; i < 64; i++) begin
      s_ena = 1'b1; s_addr = 6'(i);
      tick();
    end
    // Re-setting a pending register and setting r0 must not count.
    s_addr = 6'd5;
    tick();
    s_addr = 6'd0;
    tick();
    idle();
    r_addr = {6'd63, 6'd0};
    #1;
    checks++;
    if (pend_cnt !== 7'd63 || any_busy !== 1'b1 || pend_cnt_nb !== 7'd63) begin
      errors++;
      $display("FAIL stress_full got cnt=%0d any=%b exp 63/1", pend_cnt, any_busy);
    end
    checks++;
    if (r_busy !== 2'b10) begin
      errors++;
      $display("FAIL stress_busy got %b exp 10", r_busy);
    end
    for (int i = 1; i < 64; i++) begin
      w_ena = 1'b1; w_addr = 6'(i); w_din = 32'(i);
      tick();
    end
    idle();
    #1;
    checks++;
    if (pend_cnt !== 7'd0 || any_busy !== 1'b0 || r_busy !== 2'b00) begin
      errors++;
      $display("FAIL stress_empty got cnt=%0d any=%b busy=%b exp 0/0/00",
               pend_cnt, any_busy, r_busy);
    end
    checks++;
    if (r_dout !== {32'd63, 32'd0}) begin
      errors++;
      $display("FAIL stress_data got %h exp 0000003f00000000", r_dout);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    r_addr = '0;
    w_ena  = 1'b0;
    w_addr = '0;
    w_din  = '0;
    s_ena  = 1'b0;
    s_addr = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_set_clear();
    test_count_stress();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
